// File: rtl/timer_string_serializer.sv
// Serialises a packed BCD timer value into an ASCII character stream
// (optional ':' separator, optional leading-zero blanking) over valid/ready.
module timer_string_serializer #(
    parameter int NUM_DIGITS = 4,
    parameter int SEP_POS    = 2,
    parameter int BLANK_LEAD = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic                    start,
    input  logic                    char_ready,
    output logic [7:0]              char_out,
    output logic                    char_valid,
    output logic                    busy,
    output logic                    done,
    output logic                    bcd_err,
    output logic [1:0]              state_dbg
);

    // Handshake: a character moves on a rising edge where char_valid and
    // char_ready are both high; while char_valid is high and char_ready is
    // low, char_out and char_valid hold until that transfer happens.

    localparam int         W        = 4 * NUM_DIGITS;
    localparam bit         HAS_SEP  = (SEP_POS > 0);
    localparam int         TOTAL    = NUM_DIGITS + (HAS_SEP ? 1 : 0);
    localparam logic [3:0] LAST_IDX = 4'(TOTAL - 1);
    localparam logic [3:0] SEP_IDX  = 4'(SEP_POS);
    localparam logic [3:0] LAST_DIG = 4'(NUM_DIGITS - 1);
    localparam logic [3:0] PRE_SEP  = 4'(HAS_SEP ? SEP_POS - 1 : NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [W-1:0]   shreg;     // digits not yet emitted, next digit at the top
    logic [3:0]     idx;       // index of the character currently presented
    logic           seen_nz;   // blanking has ended for this string

    logic [3:0]     ld_dig;
    logic [7:0]     ld_char;
    logic [3:0]     nx_idx;
    logic           nx_sep;
    logic [3:0]     nx_dig;
    logic [3:0]     nx_didx;
    logic [7:0]     nx_char;

    // didx is the digit position from the left, ignoring the separator.
    function automatic logic [7:0] digit_char(input logic [3:0] dig,
                                              input logic [3:0] didx,
                                              input logic       seen);
        logic keep;
        keep = (didx == LAST_DIG) || (HAS_SEP && (didx == PRE_SEP));
        if (dig > 4'd9)
            digit_char = 8'h3F;
        else if ((BLANK_LEAD != 0) && !seen && (dig == 4'd0) && !keep)
            digit_char = 8'h20;
        else
            digit_char = {4'h3, dig};
    endfunction

    always_comb begin
        ld_dig  = bcd_in[W-1 -: 4];
        ld_char = digit_char(ld_dig, 4'd0, 1'b0);
        nx_idx  = idx + 4'd1;
        nx_sep  = HAS_SEP && (nx_idx == SEP_IDX);
        nx_dig  = shreg[W-1 -: 4];
        nx_didx = (HAS_SEP && (nx_idx > SEP_IDX)) ? nx_idx - 4'd1 : nx_idx;
        nx_char = nx_sep ? 8'h3A : digit_char(nx_dig, nx_didx, seen_nz);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shreg      <= '0;
            idx        <= 4'd0;
            seen_nz    <= 1'b0;
            char_out   <= 8'h00;
            char_valid <= 1'b0;
            done       <= 1'b0;
            bcd_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        // The first digit is consumed straight from bcd_in.
                        shreg      <= bcd_in << 4;
                        idx        <= 4'd0;
                        bcd_err    <= (ld_dig > 4'd9);
                        seen_nz    <= (ld_char != 8'h20);
                        char_out   <= ld_char;
                        char_valid <= 1'b1;
                        state      <= EMIT;
                    end
                end
                EMIT: begin
                    if (char_valid && char_ready) begin
                        if (idx == LAST_IDX) begin
                            char_out   <= 8'h00;
                            char_valid <= 1'b0;
                            done       <= 1'b1;
                            state      <= DONE;
                        end else begin
                            idx      <= nx_idx;
                            char_out <= nx_char;
                            if (!nx_sep) begin
                                shreg <= shreg << 4;
                                if (nx_dig > 4'd9)
                                    bcd_err <= 1'b1;
                            end
                            if (nx_char != 8'h20)
                                seen_nz <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    char_out   <= 8'h00;
                    char_valid <= 1'b0;
                    done       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_timer_string_serializer.sv
// Scoreboard bench for timer_string_serializer: default instance plus a
// BLANK_LEAD=0 instance sharing clock, reset, bcd_in and char_ready.
module tb_timer_string_serializer;

    logic        clk;
    logic        rst_n;
    logic [15:0] bcd_in;
    logic        start;
    logic        start_nb;
    logic        char_ready;

    logic [7:0]  char_out,   char_out_nb;
    logic        char_valid, char_valid_nb;
    logic        busy,       busy_nb;
    logic        done,       done_nb;
    logic        bcd_err,    bcd_err_nb;
    logic [1:0]  state_dbg,  state_dbg_nb;

    logic [7:0]  exp_q[$];
    logic [7:0]  exp_nb_q[$];

    int          n_cmp;
    int          n_err;
    int          xfer_cnt;
    logic        prev_stall;
    logic [7:0]  prev_char;

    timer_string_serializer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bcd_in     (bcd_in),
        .start      (start),
        .char_ready (char_ready),
        .char_out   (char_out),
        .char_valid (char_valid),
        .busy       (busy),
        .done       (done),
        .bcd_err    (bcd_err),
        .state_dbg  (state_dbg)
    );

    timer_string_serializer #(.NUM_DIGITS(4), .SEP_POS(2), .BLANK_LEAD(0)) dut_nb (
        .clk        (clk),
        .rst_n      (rst_n),
        .bcd_in     (bcd_in),
        .start      (start_nb),
        .char_ready (char_ready),
        .char_out   (char_out_nb),
        .char_valid (char_valid_nb),
        .busy       (busy_nb),
        .done       (done_nb),
        .bcd_err    (bcd_err_nb),
        .state_dbg  (state_dbg_nb)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        logic [7:0] e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(char_valid), 32'(1));
                check("hold_char", 32'(char_out), 32'(prev_char));
            end
            if (!char_valid)
                check("idle_char", 32'(char_out), 32'(0));
            if (char_valid && char_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_char", 32'(char_out), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("char", 32'(char_out), 32'(e));
                end
                xfer_cnt++;
            end
            prev_stall = char_valid && !char_ready;
            prev_char  = char_out;
        end
    end

    always @(negedge clk) begin
        logic [7:0] e;
        if (rst_n && char_valid_nb && char_ready) begin
            if (exp_nb_q.size() == 0) begin
                check("extra_char_nb", 32'(char_out_nb), 32'hFFFF_FFFF);
            end else begin
                e = exp_nb_q.pop_front();
                check("char_nb", 32'(char_out_nb), 32'(e));
            end
        end
    end

    // ---------------- reference model (defaults) ----------------
    function automatic logic [39:0] model_str(input logic [15:0] v);
        logic [39:0] res;
        logic [3:0]  dig;
        logic [7:0]  ch;
        logic        seen;
        res  = '0;
        seen = 1'b0;
        for (int d = 0; d < 4; d++) begin
            dig = v[15 - 4*d -: 4];
            if (dig > 4'd9) begin
                ch   = 8'h3F;
                seen = 1'b1;
            end else if (dig == 4'd0 && !seen && d != 1 && d != 3) begin
                ch = 8'h20;
            end else begin
                ch   = 8'h30 + {4'h0, dig};
                seen = 1'b1;
            end
            res = {res[31:0], ch};
            if (d == 1)
                res = {res[31:0], 8'h3A};
        end
        return res;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic push_str(input logic [39:0] s);
        for (int i = 0; i < 5; i++)
            exp_q.push_back(s[39 - 8*i -: 8]);
    endtask

    task automatic pulse_start(input logic [15:0] v);
        @(posedge clk) #1;
        bcd_in = v;
        start  = 1'b1;
        @(posedge clk) #1;
        start  = 1'b0;
    endtask

    // Waits (bounded) for the done pulse, optionally randomising char_ready.
    task automatic wait_done(input bit rnd, input bit start_in_done, input int base);
        bit got;
        got = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
            if (rnd) begin
                @(posedge clk) #1;
                char_ready = 1'($urandom_range(0, 1));
            end
        end
        check("done_seen", 32'(got), 32'(1));
        if (got && start_in_done) begin
            bcd_in = 16'h9999;
            start  = 1'b1;
            @(posedge clk) #1;
            start  = 1'b0;
            @(negedge clk);
            check("start_in_done_busy", 32'(busy), 32'(0));
            check("start_in_done_valid", 32'(char_valid), 32'(0));
        end else if (got) begin
            @(negedge clk);
            check("done_width", 32'(done), 32'(0));
        end
        check("xfers", 32'(xfer_cnt - base), 32'(5));
        check("q_empty", 32'(exp_q.size()), 32'(0));
        char_ready = 1'b1;
    endtask

    // Back-to-back string with char_ready held high and cycle-exact checks.
    task automatic run_timed(input logic [15:0] v, input logic [39:0] s, input int err_from,
                             input bit with_nb, input logic [39:0] s_nb);
        int base;
        char_ready = 1'b1;
        push_str(s);
        if (with_nb)
            for (int i = 0; i < 5; i++)
                exp_nb_q.push_back(s_nb[39 - 8*i -: 8]);
        base = xfer_cnt;
        @(posedge clk) #1;
        bcd_in   = v;
        start    = 1'b1;
        start_nb = with_nb;
        @(posedge clk) #1;
        start    = 1'b0;
        start_nb = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("valid_seq", 32'(char_valid), 32'(1));
            check("busy_seq", 32'(busy), 32'(1));
            check("done_early", 32'(done), 32'(0));
            check("err_seq", 32'(bcd_err), 32'(i >= err_from));
        end
        @(negedge clk);
        check("done_pulse", 32'(done), 32'(1));
        check("valid_in_done", 32'(char_valid), 32'(0));
        check("err_in_done", 32'(bcd_err), 32'(err_from < 5));
        @(negedge clk);
        check("done_width", 32'(done), 32'(0));
        check("busy_idle", 32'(busy), 32'(0));
        check("err_hold", 32'(bcd_err), 32'(err_from < 5));
        check("xfers", 32'(xfer_cnt - base), 32'(5));
        check("q_empty", 32'(exp_q.size()), 32'(0));
        if (with_nb) begin
            check("done_nb", 32'(busy_nb), 32'(0));
            check("q_nb_empty", 32'(exp_nb_q.size()), 32'(0));
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int base;
        logic [15:0] v;
        int r;
        n_cmp      = 0;
        n_err      = 0;
        xfer_cnt   = 0;
        rst_n      = 1'b0;
        bcd_in     = 16'h0000;
        start      = 1'b0;
        start_nb   = 1'b0;
        char_ready = 1'b1;

        #12;
        check("rst_char", 32'(char_out), 32'(0));
        check("rst_valid", 32'(char_valid), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_err", 32'(bcd_err), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        run_timed(16'h0305, 40'h20_33_3A_30_35, 5, 1'b0, 40'h0);
        run_timed(16'h0000, 40'h20_30_3A_30_30, 5, 1'b1, 40'h30_30_3A_30_30);
        run_timed(16'h05A9, 40'h20_35_3A_3F_39, 3, 1'b0, 40'h0);
        run_timed(16'h0908, 40'h20_39_3A_30_38, 5, 1'b0, 40'h0);

        // Back-pressure on the second character, then start during DONE.
        push_str(40'h31_32_3A_33_34);
        base = xfer_cnt;
        char_ready = 1'b1;
        pulse_start(16'h1234);
        @(posedge clk) #1;
        char_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_char", 32'(char_out), 32'(8'h32));
            check("stall_valid", 32'(char_valid), 32'(1));
            @(posedge clk);
        end
        #1;
        char_ready = 1'b1;
        wait_done(1'b0, 1'b1, base);

        // A start while emitting must not disturb the captured value.
        push_str(40'h31_32_3A_33_34);
        base = xfer_cnt;
        pulse_start(16'h1234);
        @(posedge clk) #1;
        bcd_in = 16'h9999;
        start  = 1'b1;
        @(posedge clk) #1;
        start  = 1'b0;
        wait_done(1'b0, 1'b0, base);

        // Random values with random back-pressure.
        for (int t = 0; t < 12; t++) begin
            for (int d = 0; d < 4; d++) begin
                r = $urandom_range(0, 9);
                if (r < 4)      v[15 - 4*d -: 4] = 4'd0;
                else if (r < 8) v[15 - 4*d -: 4] = 4'($urandom_range(1, 9));
                else            v[15 - 4*d -: 4] = 4'($urandom_range(10, 15));
            end
            push_str(model_str(v));
            base = xfer_cnt;
            char_ready = 1'($urandom_range(0, 1));
            pulse_start(v);
            wait_done(1'b1, 1'b0, base);
        end

        // Reset mid-string, then a fresh string with no resumption.
        push_str(40'h31_32_3A_33_34);
        char_ready = 1'b1;
        pulse_start(16'h1234);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk) #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_char", 32'(char_out), 32'(0));
        check("async_rst_valid", 32'(char_valid), 32'(0));
        check("async_rst_busy", 32'(busy), 32'(0));
        check("async_rst_done", 32'(done), 32'(0));
        check("async_rst_err", 32'(bcd_err), 32'(0));
        exp_q.delete();
        exp_nb_q.delete();
        #3;
        push_str(40'h20_31_3A_30_30);
        base   = xfer_cnt;
        rst_n  = 1'b1;
        bcd_in = 16'h0100;
        start  = 1'b1;
        @(posedge clk) #1;
        start  = 1'b0;
        @(negedge clk);
        check("first_start_valid", 32'(char_valid), 32'(1));
        wait_done(1'b0, 1'b0, base);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
